// File: rtl/video_timing_driver.sv
// video_timing_driver
//   Raster timing generator and pull side of the pixel interface.
//   Free-running h/v counters produce raw sync/active timing. A request
//   window that leads the active region by PIX_LAT cycles tells the pixel
//   generator which pixel to fetch. Sync, DE, RGB and frame_start are
//   registered together so they stay aligned one cycle behind the counters.
// Ports
//   pixel_clk   : pixel clock (all logic in this domain)
//   sys_rst_n   : asynchronous active-low reset
//   pixel_data  : RGB888 returned PIX_LAT cycles after the matching request
//   data_req    : pixel_xpos/pixel_ypos carry a live request (combinational)
//   pixel_xpos  : requested column, 0 when data_req=0
//   pixel_ypos  : current active row, 0 outside active lines
//   frame_start : one-cycle pulse at the start of each frame
//   video_hs/vs : syncs, active level set by SYNC_POL
//   video_de    : active-video data enable
//   video_rgb   : output pixel, 0 whenever video_de=0
module video_timing_driver #(
  parameter int H_SYNC   = 44,
  parameter int H_BACK   = 148,
  parameter int H_DISP   = 1920,
  parameter int H_FRONT  = 88,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 36,
  parameter int V_DISP   = 1080,
  parameter int V_FRONT  = 4,
  parameter int SYNC_POL = 1,
  parameter int PIX_LAT  = 2
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] pixel_data,
  output logic        data_req,
  output logic [11:0] pixel_xpos,
  output logic [11:0] pixel_ypos,
  output logic        frame_start,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_END = 12'(H_SYNC);
  localparam logic [11:0] VS_END = 12'(V_SYNC);
  localparam logic [11:0] HA_BEG = 12'(HA);
  localparam logic [11:0] HA_END = 12'(HA + H_DISP);
  localparam logic [11:0] VA_BEG = 12'(VA);
  localparam logic [11:0] VA_END = 12'(VA + V_DISP);
  // Request window is evaluated on h_cnt+PIX_LAT in 13 bits so that a
  // window starting at h_cnt=0 (PIX_LAT=HA) needs no compare against zero.
  localparam logic [12:0] RQ_BEG = 13'(HA);
  localparam logic [12:0] RQ_END = 13'(HA + H_DISP);
  localparam logic [12:0] LAT    = 13'(PIX_LAT);
  localparam logic        POL    = 1'(SYNC_POL);

  logic [11:0] h_cnt, v_cnt;
  logic        hs_raw, vs_raw, h_act, v_act, de_raw;
  logic [12:0] h_lead, x_off;

  // Line wrap and frame wrap happen on the same edge as h_cnt -> 0.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_comb begin
    hs_raw = (h_cnt < HS_END);
    vs_raw = (v_cnt < VS_END);
    h_act  = (h_cnt >= HA_BEG) && (h_cnt < HA_END);
    v_act  = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
    de_raw = h_act && v_act;

    // Request k goes out at h_cnt = HA-PIX_LAT+k so its data arrives at HA+k.
    h_lead     = {1'b0, h_cnt} + LAT;
    x_off      = h_lead - RQ_BEG;
    data_req   = v_act && (h_lead >= RQ_BEG) && (h_lead < RQ_END);
    pixel_xpos = data_req ? x_off[11:0] : '0;
    pixel_ypos = v_act ? (v_cnt - VA_BEG) : '0;
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      video_de    <= 1'b0;
      video_rgb   <= '0;
      frame_start <= 1'b0;
      video_hs    <= ~POL;
      video_vs    <= ~POL;
    end else begin
      video_de    <= de_raw;
      video_rgb   <= de_raw ? pixel_data : 24'd0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      video_hs    <= POL ? hs_raw : ~hs_raw;
      video_vs    <= POL ? vs_raw : ~vs_raw;
    end
  end

endmodule

// File: tb/tb_video_timing_driver.sv
// Bench for video_timing_driver on a reduced raster (29x13 clocks) so
// full frames fit in a short run. Three builds share clock and reset:
// PIX_LAT=2/active-high, PIX_LAT=0, and active-low sync.
module tb_video_timing_driver;

  localparam int HS = 4, HB = 6, HD = 16, HF = 3;
  localparam int VS = 2, VB = 3, VD = 6, VF = 2;
  localparam int HT = HS + HB + HD + HF;   // 29
  localparam int VT = VS + VB + VD + VF;   // 13
  localparam int HA = HS + HB;             // 10
  localparam int VA = VS + VB;             // 5
  localparam int FRAME = HT * VT;          // 377

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // build A: PIX_LAT=2, active-high sync
  logic [23:0] pd_a, rgb_a;
  logic        req_a, fs_a, hs_a, vs_a, de_a;
  logic [11:0] x_a, y_a;
  // build B: PIX_LAT=0
  logic [23:0] pd_b, rgb_b;
  logic        req_b, fs_b, hs_b, vs_b, de_b;
  logic [11:0] x_b, y_b;
  // build C: active-low sync
  logic [23:0] pd_c, rgb_c;
  logic        req_c, fs_c, hs_c, vs_c, de_c;
  logic [11:0] x_c, y_c;

  video_timing_driver #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .SYNC_POL(1), .PIX_LAT(2))
  u_dut (.pixel_clk(clk), .sys_rst_n(rst_n), .pixel_data(pd_a), .data_req(req_a),
    .pixel_xpos(x_a), .pixel_ypos(y_a), .frame_start(fs_a), .video_hs(hs_a),
    .video_vs(vs_a), .video_de(de_a), .video_rgb(rgb_a));

  video_timing_driver #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .SYNC_POL(1), .PIX_LAT(0))
  u_dut0 (.pixel_clk(clk), .sys_rst_n(rst_n), .pixel_data(pd_b), .data_req(req_b),
    .pixel_xpos(x_b), .pixel_ypos(y_b), .frame_start(fs_b), .video_hs(hs_b),
    .video_vs(vs_b), .video_de(de_b), .video_rgb(rgb_b));

  video_timing_driver #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .SYNC_POL(0), .PIX_LAT(2))
  u_dutn (.pixel_clk(clk), .sys_rst_n(rst_n), .pixel_data(pd_c), .data_req(req_c),
    .pixel_xpos(x_c), .pixel_ypos(y_c), .frame_start(fs_c), .video_hs(hs_c),
    .video_vs(vs_c), .video_de(de_c), .video_rgb(rgb_c));

  // Pixel generator models: A returns {ypos,xpos} two cycles late,
  // B returns it with zero latency, C returns a constant.
  logic [23:0] gen_p0, gen_p1;
  always @(posedge clk) begin
    gen_p0 <= {y_a, x_a};
    gen_p1 <= gen_p0;
  end
  assign pd_a = gen_p1;
  assign pd_b = {y_b, x_b};
  assign pd_c = 24'hA5A5A5;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference raster position, restarted by reset.
  int hm, vm;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hm <= 0; vm <= 0;
    end else if (hm == HT - 1) begin
      hm <= 0;
      vm <= (vm == VT - 1) ? 0 : vm + 1;
    end else begin
      hm <= hm + 1;
    end
  end

  function automatic logic v_on(input int v);
    return v >= VA && v < VA + VD;
  endfunction
  function automatic logic req_on(input int h, input int v, input int lat);
    return v_on(v) && h >= HA - lat && h < HA + HD - lat;
  endfunction

  typedef struct {
    logic de, hs, vs, fs, hsn, vsn;
    logic [23:0] rgb, rgbn;
  } exp_t;

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    logic [11:0] yy, xx;
    yy = 12'(v - VA);
    xx = 12'(h - HA);
    e.de   = v_on(v) && h >= HA && h < HA + HD;
    e.hs   = h < HS;
    e.vs   = v < VS;
    e.fs   = (h == 0) && (v == 0);
    e.hsn  = !(h < HS);
    e.vsn  = !(v < VS);
    e.rgb  = e.de ? {yy, xx} : 24'd0;
    e.rgbn = e.de ? 24'hA5A5A5 : 24'd0;
    return e;
  endfunction

  // Scoreboard: each negedge pushes what the registers must show after the
  // next edge, and pops/compares the entry pushed one cycle earlier.
  exp_t sbq[$];
  exp_t se;
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      chk("rst de", de_a, 0);     chk("rst rgb", rgb_a, 0);
      chk("rst fs", fs_a, 0);     chk("rst req", req_a, 0);
      chk("rst hs", hs_a, 0);     chk("rst vs", vs_a, 0);
      chk("rst hs_n", hs_c, 1);   chk("rst vs_n", vs_c, 1);
    end else begin
      if (sbq.size() > 0) begin
        se = sbq.pop_front();
        chk("de", de_a, se.de);     chk("rgb", rgb_a, se.rgb);
        chk("hs", hs_a, se.hs);     chk("vs", vs_a, se.vs);
        chk("fs", fs_a, se.fs);
        chk("de lat0", de_b, se.de);   chk("rgb lat0", rgb_b, se.rgb);
        chk("hs_n", hs_c, se.hsn);     chk("vs_n", vs_c, se.vsn);
        chk("rgb pol0", rgb_c, se.rgbn);
      end
      chk("req", req_a, req_on(hm, vm, 2));
      chk("xpos", x_a, req_on(hm, vm, 2) ? 32'(hm - (HA - 2)) : 0);
      chk("ypos", y_a, v_on(vm) ? 32'(vm - VA) : 0);
      chk("req lat0", req_b, req_on(hm, vm, 0));
      chk("xpos lat0", x_b, req_on(hm, vm, 0) ? 32'(hm - HA) : 0);
    end
    sbq.push_back(model(hm, vm));
  end

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    @(negedge clk);
    while (!(hm == h && vm == v) && n < 2 * FRAME + 5) begin
      @(negedge clk);
      n++;
    end
    if (!(hm == h && vm == v)) begin
      n_tests++; n_fail++;
      $display("FAIL wait_hv(%0d,%0d): timed out, expected position not reached", h, v);
    end
  endtask

  typedef struct { int h; int v; logic req; int x; int y; } vec_t;
  vec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, de_cnt, hs_cnt, vs_cnt, fs_cnt, rq_cnt, hsn_lo, vsn_lo, hs_bad, last_rise;
    logic hs_prev;

    tbl = '{
      '{7, 5, 0, 0, 0},  '{8, 5, 1, 0, 0},  '{9, 5, 1, 1, 0},
      '{12, 6, 1, 4, 1}, '{23, 5, 1, 15, 0}, '{24, 5, 0, 0, 0},
      '{8, 4, 0, 0, 0},  '{0, 7, 0, 0, 2},  '{8, 10, 1, 0, 5},
      '{23, 10, 1, 15, 5}, '{8, 11, 0, 0, 0}};

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // request window spot checks, PIX_LAT=2
    foreach (tbl[i]) begin
      wait_hv(tbl[i].h, tbl[i].v);
      chk($sformatf("tbl%0d req", i), req_a, tbl[i].req);
      chk($sformatf("tbl%0d xpos", i), x_a, tbl[i].x);
      chk($sformatf("tbl%0d ypos", i), y_a, tbl[i].y);
    end

    // no requests at all on the line before and after the active window
    for (int k = 0; k < 2; k++) begin
      wait_hv(0, (k == 0) ? VA - 1 : VA + VD);
      cnt = 0;
      for (int i = 0; i < HT; i++) begin
        if (req_a) cnt++;
        @(negedge clk);
      end
      chk($sformatf("req on blank line %0d", k), cnt, 0);
    end

    // PIX_LAT=0: request rises with de_raw, video_de one cycle later
    wait_hv(HA - 1, VA);
    chk("lat0 req before", req_b, 0);
    @(negedge clk);
    chk("lat0 req rise", req_b, 1);
    chk("lat0 xpos rise", x_b, 0);
    chk("lat0 de not yet", de_b, 0);
    @(negedge clk);
    chk("lat0 de rise", de_b, 1);

    // two full frames of counts, aligned to frame_start
    cnt = 0;
    while (!fs_a && cnt < FRAME + 5) begin
      @(negedge clk);
      cnt++;
    end
    chk("fs found", fs_a, 1);
    for (int f = 0; f < 2; f++) begin
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; rq_cnt = 0;
      hsn_lo = 0; vsn_lo = 0; hs_bad = 0; last_rise = 0; hs_prev = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clk);
        if (de_a) de_cnt++;
        if (hs_a) hs_cnt++;
        if (vs_a) vs_cnt++;
        if (fs_a) fs_cnt++;
        if (req_a) rq_cnt++;
        if (!hs_c) hsn_lo++;
        if (!vs_c) vsn_lo++;
        if (hs_a && !hs_prev) begin
          if (i - last_rise != HT) hs_bad++;
          last_rise = i;
        end
        hs_prev = hs_a;
      end
      @(negedge clk);
      chk($sformatf("f%0d de count", f), de_cnt, HD * VD);
      chk($sformatf("f%0d req count", f), rq_cnt, HD * VD);
      chk($sformatf("f%0d hs high", f), hs_cnt, HS * VT);
      chk($sformatf("f%0d vs high", f), vs_cnt, VS * HT);
      chk($sformatf("f%0d hs period errs", f), hs_bad, 0);
      chk($sformatf("f%0d fs pulses", f), fs_cnt, 1);
      chk($sformatf("f%0d fs spacing", f), fs_a, 1);
      chk($sformatf("f%0d hs_n low", f), hsn_lo, HS * VT);
      chk($sformatf("f%0d vs_n low", f), vsn_lo, VS * HT);
    end

    // reset mid-frame: outputs drop immediately, frame restarts cleanly
    wait_hv(15, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst de", de_a, 0);
    chk("mid rst rgb", rgb_a, 0);
    chk("mid rst hs", hs_a, 0);
    chk("mid rst vs", vs_a, 0);
    chk("mid rst hs_n", hs_c, 1);
    chk("mid rst vs_n", vs_c, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("fs after release", fs_a, 1);
    @(negedge clk);
    chk("fs one cycle", fs_a, 0);
    repeat (HT * (VA + 2)) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
